serial_32x8: RTL and testbench

SERIAL_32X8 -- requirements
Module: serial_32x8

---
 rtl/serial_32x8.sv | 177 +++++++++++++++++
 tb/tb_serial_32x8.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_32x8.sv
// 32-bit to 8-bit serializer: one word in, four bytes out MSB first, with a one-word hold
// register so back-to-back words stream without gaps. Optional parity output: SERIAL_32X8_PARITY_EN.
module serial_32x8 (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic [31:0] data_in_32x8,
  input  logic        valid_in_32x8,
  output logic        ready_out_32x8,
  output logic [7:0]  data_out_32x8,
  output logic        valid_out_32x8,
  output logic        word_start_32x8
`ifdef SERIAL_32X8_PARITY_EN
  ,
  output logic        parity_out_32x8
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

`ifdef SERIAL_32X8_PARITY_EN
  function automatic logic parity8(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  state_t      state_r;
  logic [31:0] shifter_r;
  logic [1:0]  cnt_r;
  logic [31:0] hold_r;
  logic        hold_full_r;
  logic [7:0]  data_out_r;
  logic        valid_out_r;
  logic        word_start_r;

  logic        accept_s;
  logic        load_hold_s;
  logic        load_in_s;
  logic        advance_s;
  logic        to_hold_s;
  logic [31:0] load_word_s;
  logic [7:0]  data_nxt_s;
  logic        valid_nxt_s;
  logic        word_start_nxt_s;

  assign ready_out_32x8 = !hold_full_r;
  assign accept_s       = valid_in_32x8 && !hold_full_r;

  // Decide what the next edge does: load a word, step to the next byte, park in hold, or go idle
  always_comb begin
    load_hold_s = 1'b0;
    load_in_s   = 1'b0;
    advance_s   = 1'b0;
    to_hold_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          load_in_s = 1'b1;
        end else begin
          load_in_s = 1'b0;
        end
      end
      ST_SEND: begin
        if (cnt_r != 2'd3) begin
          advance_s = 1'b1;
          if (accept_s) begin
            to_hold_s = 1'b1;
          end else begin
            to_hold_s = 1'b0;
          end
        end else if (hold_full_r) begin
          // hold_full forces ready low, so no new word can compete with the held one here
          load_hold_s = 1'b1;
        end else if (accept_s) begin
          load_in_s = 1'b1;
        end else begin
          load_in_s = 1'b0;
        end
      end
      default: begin
        load_in_s = 1'b0;
      end
    endcase
  end

  // Next output byte and flags derived from the chosen action
  always_comb begin
    load_word_s      = load_hold_s ? hold_r : data_in_32x8;
    data_nxt_s       = 8'h00;
    valid_nxt_s      = 1'b0;
    word_start_nxt_s = 1'b0;
    if (load_hold_s || load_in_s) begin
      data_nxt_s       = load_word_s[31:24];
      valid_nxt_s      = 1'b1;
      word_start_nxt_s = 1'b1;
    end else if (advance_s) begin
      data_nxt_s       = shifter_r[23:16];
      valid_nxt_s      = 1'b1;
      word_start_nxt_s = 1'b0;
    end else begin
      data_nxt_s       = 8'h00;
      valid_nxt_s      = 1'b0;
      word_start_nxt_s = 1'b0;
    end
  end

  // Shifter, byte counter, state and registered byte outputs
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_r      <= ST_IDLE;
      shifter_r    <= 32'h0000_0000;
      cnt_r        <= 2'd0;
      data_out_r   <= 8'h00;
      valid_out_r  <= 1'b0;
      word_start_r <= 1'b0;
    end else begin
      data_out_r   <= data_nxt_s;
      valid_out_r  <= valid_nxt_s;
      word_start_r <= word_start_nxt_s;
      if (load_hold_s || load_in_s) begin
        state_r   <= ST_SEND;
        shifter_r <= load_word_s;
        cnt_r     <= 2'd0;
      end else if (advance_s) begin
        state_r   <= ST_SEND;
        shifter_r <= {shifter_r[23:0], 8'h00};
        cnt_r     <= cnt_r + 2'd1;
      end else begin
        // cnt is left alone; it only wraps on the next load
        state_r   <= ST_IDLE;
        shifter_r <= shifter_r;
        cnt_r     <= cnt_r;
      end
    end
  end

  // One-word hold register filled while a word is mid-flight
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      hold_r      <= 32'h0000_0000;
      hold_full_r <= 1'b0;
    end else if (load_hold_s) begin
      hold_r      <= hold_r;
      hold_full_r <= 1'b0;
    end else if (to_hold_s) begin
      hold_r      <= data_in_32x8;
      hold_full_r <= 1'b1;
    end else begin
      hold_r      <= hold_r;
      hold_full_r <= hold_full_r;
    end
  end

`ifdef SERIAL_32X8_PARITY_EN
  logic parity_r;

  // Even parity of the byte being registered, forced low when no byte is valid
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      parity_r <= 1'b0;
    end else if (valid_nxt_s) begin
      parity_r <= parity8(data_nxt_s);
    end else begin
      parity_r <= 1'b0;
    end
  end

  assign parity_out_32x8 = parity_r;
`endif

  assign data_out_32x8   = data_out_r;
  assign valid_out_32x8  = valid_out_r;
  assign word_start_32x8 = word_start_r;

endmodule

// File: tb/tb_serial_32x8.sv
// Self-checking bench for serial_32x8: directed scenarios plus random traffic against a
// byte-stream reference model. Parity checks are enabled with SERIAL_32X8_PARITY_EN.
module tb_serial_32x8;

  logic        clk_4f = 1'b0;
  logic        reset_L;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready;
  logic [7:0]  dout;
  logic        vout;
  logic        ws;
`ifdef SERIAL_32X8_PARITY_EN
  logic        par;
`endif

  always #5 clk_4f = ~clk_4f;

  serial_32x8 dut (
    .clk_4f          (clk_4f),
    .reset_L         (reset_L),
    .data_in_32x8    (data_in),
    .valid_in_32x8   (valid_in),
    .ready_out_32x8  (ready),
    .data_out_32x8   (dout),
    .valid_out_32x8  (vout),
    .word_start_32x8 (ws)
`ifdef SERIAL_32X8_PARITY_EN
    ,
    .parity_out_32x8 (par)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the word currently being emitted, bytes still to emit, and words waiting.
  int          m_rem;
  logic [31:0] m_cur;
  logic [31:0] m_pend[$];

  function automatic void m_reset();
    m_rem = 0;
    m_cur = 32'h0;
    m_pend.delete();
  endfunction

  function automatic logic m_ready();
    return m_pend.size() == 0;
  endfunction

  // One clock: keep emitting the current word; once its last byte is out, start the next word.
  function automatic void m_step(input logic acc, input logic [31:0] din);
    if (m_rem > 1) begin
      m_rem = m_rem - 1;
      if (acc) m_pend.push_back(din);
    end else if (m_pend.size() > 0) begin
      m_cur = m_pend.pop_front();
      m_rem = 4;
    end else if (acc) begin
      m_cur = din;
      m_rem = 4;
    end else begin
      m_rem = 0;
    end
  endfunction

  function automatic logic [7:0] m_byte();
    if (m_rem == 0) return 8'h00;
    return 8'(m_cur >> (8 * (m_rem - 1)));
  endfunction

  task automatic check_outputs();
    logic [7:0] b;
    b = m_byte();
    check("data_out", dout, b);
    check("valid_out", vout, m_rem > 0);
    check("word_start", ws, m_rem == 4);
`ifdef SERIAL_32X8_PARITY_EN
    check("parity_out", par, ^b);
`endif
  endtask

  task automatic cyc(input logic v, input logic [31:0] d);
    logic acc;
    valid_in = v;
    data_in  = d;
    check("ready_out", ready, m_ready());
    acc = v && m_ready();
    @(posedge clk_4f);
    #1;
    m_step(acc, d);
    check_outputs();
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    reset_L  = 1'b0;
    m_reset();
    #1;
    check_outputs();
    check("ready_in_reset", ready, 1'b1);
    @(posedge clk_4f);
    #1;
    check_outputs();
    reset_L = 1'b1;
    #1;
    check("ready_after_rst", ready, 1'b1);
  endtask

  logic [7:0] got[8];
  logic [7:0] exp_b2b[8];
  logic [7:0] exp_dbe[5];
  logic [3:0] exp_par;

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 32'h0;
    m_reset();
    do_reset();

    // Single word from idle
    exp_dbe = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    cyc(1'b1, 32'hDEADBEEF);
    check("single_byte0", dout, exp_dbe[0]);
    check("single_ws0", ws, 1'b1);
    for (int i = 1; i < 5; i++) begin
      cyc(1'b0, 32'h0);
      check("single_byte", dout, exp_dbe[i]);
      check("single_ws", ws, 1'b0);
      check("single_valid", vout, i < 4);
    end
    repeat (3) cyc(1'b0, 32'h0);

    // Back-to-back words form one gap-free byte stream
    exp_b2b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    cyc(1'b1, 32'h01020304);
    got[0] = dout;
    check("b2b_valid", vout, 1'b1);
    cyc(1'b1, 32'hA1A2A3A4);
    got[1] = dout;
    check("b2b_valid", vout, 1'b1);
    for (int i = 2; i < 8; i++) begin
      cyc(1'b0, 32'h0);
      got[i] = dout;
      check("b2b_valid", vout, 1'b1);
      check("b2b_ws", ws, i == 4);
    end
    for (int i = 0; i < 8; i++) check("b2b_byte", got[i], exp_b2b[i]);
    cyc(1'b0, 32'h0);
    check("b2b_end_valid", vout, 1'b0);

    // Backpressure: a third word waits while hold is full
    cyc(1'b1, 32'h10203040);
    cyc(1'b1, 32'h50607080);
    check("bp_ready_low", ready, 1'b0);
    repeat (6) cyc(1'b1, 32'h90A0B0C0);
    repeat (12) cyc(1'b0, 32'h0);

    // Reset mid-word with a word held
    cyc(1'b1, 32'hDEADBEEF);
    cyc(1'b1, 32'h11223344);
    check("rst_mid_byte", dout, 8'hAD);
    do_reset();
    check("rst_mid_dout", dout, 8'h00);
    check("rst_mid_valid", vout, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 32'h0);
      check("rst_no_residual", vout, 1'b0);
    end

    // Parity pattern across one word
    exp_par = 4'b1001;
    cyc(1'b1, 32'h07FF0001);
`ifdef SERIAL_32X8_PARITY_EN
    check("par_pattern", par, exp_par[3]);
`endif
    for (int i = 1; i < 5; i++) begin
      cyc(1'b0, 32'h0);
`ifdef SERIAL_32X8_PARITY_EN
      if (i < 4) check("par_pattern", par, exp_par[3 - i]);
      else check("par_idle", par, 1'b0);
`endif
    end

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 99) < 65, $urandom);
      end
    end
    repeat (8) cyc(1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
